// File: rtl/muller_c_array.sv
// muller_c_array
//   Clocked emulation of a bank of generalised Muller C-elements. Each of
//   CHANNELS channels combines INPUTS inputs (with per-input inversion) under
//   the C rule: all ones -> 1, all zeros -> 0, otherwise hold. In pipeline
//   mode the channels form a Muller micropipeline with req/ack endpoints
//   taken from io_in. Per-channel saturating toggle counters are provided.
//
// Ports
//   wb_clk_i   : clock
//   wb_rst_i   : synchronous reset, active high
//   io_in      : raw inputs, bit i*INPUTS+j = channel i, input j
//   inv_mask   : per-input inversion, same layout (quasi-static)
//   mode       : 00 independent, 01 pipeline, 10/11 freeze
//   cnt_clr    : synchronous clear of all toggle counters
//   c_out      : C-element states
//   trans_cnt  : toggle counters, channel i at [i*CNT_W +: CNT_W]
//   busy       : 1 iff any c_out bit changed on the previous edge
module muller_c_array #(
  parameter int unsigned           CHANNELS    = 4,
  parameter int unsigned           INPUTS      = 3,
  parameter int unsigned           CNT_W       = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0]   INIT_VAL    = '0
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [CHANNELS*INPUTS-1:0]   io_in,
  input  logic [CHANNELS*INPUTS-1:0]   inv_mask,
  input  logic [1:0]                   mode,
  input  logic                         cnt_clr,
  output logic [CHANNELS-1:0]          c_out,
  output logic [CHANNELS*CNT_W-1:0]    trans_cnt,
  output logic                         busy
);

  localparam int unsigned NBITS = CHANNELS * INPUTS;

  logic [NBITS-1:0]    sync_q [SYNC_STAGES];
  logic [NBITS-1:0]    eff;
  logic [CHANNELS-1:0] c_next;
  logic [CHANNELS-1:0] toggles;
  logic [CHANNELS-1:0] left_in;
  logic [CHANNELS-1:0] right_nin;

  // Input synchroniser chain.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= io_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign eff = sync_q[SYNC_STAGES-1] ^ inv_mask;

  // Pipeline neighbours: stage i sees L = c[i-1] (req_in for stage 0) and
  // R = c[i+1] (ack_in for the last stage); R enters the C-element inverted.
  assign left_in   = {c_out[CHANNELS-2:0], eff[0]};
  assign right_nin = ~{eff[(CHANNELS-1)*INPUTS+1], c_out[CHANNELS-1:1]};

  always_comb begin
    c_next = c_out;
    case (mode)
      2'b00: begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (&eff[i*INPUTS +: INPUTS]) begin
            c_next[i] = 1'b1;
          end else if (~|eff[i*INPUTS +: INPUTS]) begin
            c_next[i] = 1'b0;
          end
        end
      end
      2'b01: begin
        // Two-input C-element as a majority of (L, ~R, current state).
        c_next = (left_in & right_nin) | (c_out & (left_in | right_nin));
      end
      default: c_next = c_out;
    endcase
  end

  assign toggles = c_next ^ c_out;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      c_out     <= INIT_VAL;
      trans_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      c_out <= c_next;
      busy  <= |toggles;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (cnt_clr) begin
          trans_cnt[i*CNT_W +: CNT_W] <= '0;
        end else if (toggles[i] && (trans_cnt[i*CNT_W +: CNT_W] != '1)) begin
          trans_cnt[i*CNT_W +: CNT_W] <= trans_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_muller_c_array.sv
// tb_muller_c_array
//   Two instances share all stimulus: dut_a (INIT_VAL=0101, 8-bit counters)
//   and dut_b (INIT_VAL=0000, 2-bit counters). A behavioural model tracks both
//   and is compared after every edge; directed steps add fixed-value checks.
module tb_muller_c_array;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] io;
  logic [11:0] mask;
  logic [1:0]  mode;
  logic        clr;

  logic [3:0]  a_c, b_c;
  logic [31:0] a_cnt;
  logic [7:0]  b_cnt;
  logic        a_busy, b_busy;

  int checks = 0;
  int fails  = 0;

  // Model state, index 0 = dut_a, 1 = dut_b.
  logic [11:0] q_in[$];
  logic [3:0]  m_c    [2];
  int          m_cnt  [2][4];
  bit          m_busy [2];
  int          m_max  [2];
  logic [3:0]  m_init [2];

  always #5 clk = ~clk;

  muller_c_array #(
    .CHANNELS(4), .INPUTS(3), .CNT_W(8), .SYNC_STAGES(2), .INIT_VAL(4'b0101)
  ) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .io_in(io), .inv_mask(mask), .mode(mode),
    .cnt_clr(clr), .c_out(a_c), .trans_cnt(a_cnt), .busy(a_busy)
  );

  muller_c_array #(
    .CHANNELS(4), .INPUTS(3), .CNT_W(2), .SYNC_STAGES(2), .INIT_VAL(4'b0000)
  ) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .io_in(io), .inv_mask(mask), .mode(mode),
    .cnt_clr(clr), .c_out(b_c), .trans_cnt(b_cnt), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference for one clock edge, using current tb inputs.
  task automatic model_edge();
    logic [11:0] s, e;
    logic [3:0]  old, nxt;
    int          ones;
    bit          l, r;
    if (rst) begin
      q_in.delete();
      q_in.push_back(12'h000);
      q_in.push_back(12'h000);
      for (int k = 0; k < 2; k++) begin
        m_c[k] = m_init[k];
        m_busy[k] = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
      end
      return;
    end
    // Value visible at the synchroniser output is io sampled two edges ago.
    s = q_in.pop_front();
    q_in.push_back(io);
    e = s ^ mask;
    for (int k = 0; k < 2; k++) begin
      old = m_c[k];
      nxt = old;
      if (mode == 2'b00) begin
        for (int i = 0; i < 4; i++) begin
          ones = 0;
          for (int j = 0; j < 3; j++) ones += int'(e[i*3+j]);
          if (ones == 3) nxt[i] = 1'b1;
          else if (ones == 0) nxt[i] = 1'b0;
        end
      end else if (mode == 2'b01) begin
        for (int i = 0; i < 4; i++) begin
          if (i == 0) l = e[0]; else l = old[i-1];
          if (i == 3) r = e[10]; else r = old[i+1];
          if (l && !r) nxt[i] = 1'b1;
          else if (!l && r) nxt[i] = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (clr) m_cnt[k][i] = 0;
        else if (nxt[i] != old[i] && m_cnt[k][i] < m_max[k]) m_cnt[k][i]++;
      end
      m_busy[k] = (nxt != old);
      m_c[k] = nxt;
    end
  endtask

  task automatic check_model();
    logic [31:0] ea;
    logic [7:0]  eb;
    for (int i = 0; i < 4; i++) begin
      ea[i*8 +: 8] = 8'(m_cnt[0][i]);
      eb[i*2 +: 2] = 2'(m_cnt[1][i]);
    end
    chk("a_c_out", 32'(a_c), 32'(m_c[0]));
    chk("a_busy", 32'(a_busy), 32'(m_busy[0]));
    chk("a_trans_cnt", a_cnt, ea);
    chk("b_c_out", 32'(b_c), 32'(m_c[1]));
    chk("b_busy", 32'(b_busy), 32'(m_busy[1]));
    chk("b_trans_cnt", 32'(b_cnt), 32'(eb));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    m_max[0] = 255;  m_max[1] = 3;
    m_init[0] = 4'b0101; m_init[1] = 4'b0000;
    rst = 1'b1; io = '0; mask = '0; mode = 2'b10; clr = 1'b0;
    #2;

    // 1: reset into freeze, values held with random inputs.
    do_reset();
    chk("t1_reset_c", 32'(a_c), 32'h5);
    chk("t1_reset_cnt", a_cnt, 32'h0);
    chk("t1_reset_busy", 32'(a_busy), 32'h0);
    for (int n = 0; n < 10; n++) begin
      io = 12'($urandom);
      step();
      chk("t1_hold_c", 32'(a_c), 32'h5);
      chk("t1_hold_cnt", a_cnt, 32'h0);
    end

    // 2: independent mode, latency and hold on ch0.
    io = '0; mode = 2'b00;
    do_reset();
    io = 12'h007;
    step(); chk("t2_e1", 32'(b_c[0]), 32'h0);
    step(); chk("t2_e2", 32'(b_c[0]), 32'h0);
    step(); chk("t2_e3", 32'(b_c[0]), 32'h1);
    chk("t2_busy_on", 32'(b_busy), 32'h1);
    io = 12'h006;
    step(); chk("t2_busy_off", 32'(b_busy), 32'h0);
    for (int n = 0; n < 4; n++) step();
    chk("t2_hold", 32'(b_c[0]), 32'h1);
    io = 12'h000;
    step(); step(); chk("t2_fall_e2", 32'(b_c[0]), 32'h1);
    step(); chk("t2_fall_e3", 32'(b_c[0]), 32'h0);
    chk("t2_busy_fall", 32'(b_busy), 32'h1);
    chk("t2_cnt", 32'(b_cnt[1:0]), 32'h2);
    step(); chk("t2_busy_clear", 32'(b_busy), 32'h0);

    // 3: inversion mask on ch1.
    io = 12'h018; mask = 12'h020;
    for (int n = 0; n < 3; n++) step();
    chk("t3_inv_set", 32'(b_c[1]), 32'h1);
    mask = '0;
    for (int n = 0; n < 4; n++) step();
    chk("t3_inv_hold", 32'(b_c[1]), 32'h1);

    // 4: pipeline fill, ack hold, req drop. Non-endpoint bits are random.
    mode = 2'b01;
    do_reset();
    io = (12'($urandom) & 12'hBFE) | 12'h001;
    step(); step(); chk("t4_e2", 32'(b_c), 32'h0);
    io = (12'($urandom) & 12'hBFE) | 12'h001;
    step(); chk("t4_e3", 32'(b_c), 32'h1);
    step(); chk("t4_e4", 32'(b_c), 32'h3);
    step(); chk("t4_e5", 32'(b_c), 32'h7);
    step(); chk("t4_e6", 32'(b_c), 32'hF);
    io = (12'($urandom) & 12'hBFE) | 12'h401;
    for (int n = 0; n < 4; n++) step();
    chk("t4_ack_hold", 32'(b_c), 32'hF);
    io = (12'($urandom) & 12'hBFE) | 12'h400;
    step(); step(); step();
    chk("t4_req_drop", 32'(b_c), 32'hE);

    // 6: reset with a token mid-flight.
    io = 12'h001;
    do_reset();
    for (int n = 0; n < 4; n++) step();
    chk("t6_midflight", 32'(b_c), 32'h3);
    do_reset();
    chk("t6_reset_c", 32'(b_c), 32'h0);
    chk("t6_reset_cnt", 32'(b_cnt), 32'h0);
    step(); step(); chk("t6_e2", 32'(b_c[0]), 32'h0);
    step(); chk("t6_e3", 32'(b_c[0]), 32'h1);

    // 5: counter saturation on ch2 (2-bit counters), clear beats toggle.
    mode = 2'b00; io = '0;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      io = (n % 2 == 0) ? 12'h1C0 : 12'h000;
      step();
    end
    chk("t5_saturate", 32'(b_cnt[5:4]), 32'h3);
    io = 12'h000; clr = 1'b1;
    step();
    chk("t5_clr_toggle_busy", 32'(b_busy), 32'h1);
    chk("t5_clr", 32'(b_cnt[5:4]), 32'h0);
    clr = 1'b0;

    // Random phase against the model.
    for (int n = 0; n < 400; n++) begin
      io   = 12'($urandom);
      if ($urandom_range(0, 7) == 0) mask = 12'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      clr  = ($urandom_range(0, 19) == 0);
      rst  = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0; clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
